// File: rtl/phase_sequencer_if.sv
// Control, status and counter-feedback signals of the phase sequencer.
// The slave modport is the sequencer; master is the host/counter side.
interface phase_sequencer_if #(
  parameter int unsigned NPHASE = 4,
  parameter int unsigned CW     = 4
);
  logic                 start;
  logic                 pause;
  logic                 abort;
  logic [NPHASE*CW-1:0] dur;
  logic [CW-1:0]        count;
  logic                 counten;
  logic                 cntclr;
  logic [1:0]           phase;
  logic                 busy;
  logic                 paused;
  logic                 done;

  modport master (
    output start, pause, abort, dur, count,
    input  counten, cntclr, phase, busy, paused, done
  );

  modport slave (
    input  start, pause, abort, dur, count,
    output counten, cntclr, phase, busy, paused, done
  );
endinterface

// File: rtl/phase_sequencer.sv
// Multi-phase timing controller driving an external up-counter's enable/clear.
// Each phase runs until the fed-back count reaches that phase's captured duration.
module phase_sequencer #(
  parameter int unsigned NPHASE = 4,
  parameter int unsigned CW     = 4,
  parameter int unsigned LOOP   = 0
) (
  input logic              clk,
  input logic              reset,
  phase_sequencer_if.slave sif
);

  localparam int unsigned DW = NPHASE * CW;
  localparam int unsigned PW = 2;

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, PAUSE, DONE} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [DW-1:0]   dur_q, dur_d;
  logic            busy_q, busy_d;
  logic            paused_q, paused_d;
  logic            done_q, done_d;
  logic [CW-1:0]   dur_sel;
  logic            terminal;
  logic            last_phase;
  logic            loop_done;

  always_comb begin
    dur_sel = '0;
    for (int i = 0; i < int'(NPHASE); i++) begin
      if (phase_q == PW'(i)) dur_sel = dur_q[i*CW +: CW];
    end
  end

  // Anything at or past the terminal count ends the phase, so a faulty counter cannot run away.
  assign terminal   = (sif.count >= dur_sel);
  assign last_phase = (phase_q == PW'(NPHASE - 1));

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    dur_d     = dur_q;
    loop_done = 1'b0;
    case (state_q)
      IDLE: begin
        if (sif.start) begin
          state_d = CLEAR;
          phase_d = '0;
          dur_d   = sif.dur;
        end
      end
      CLEAR: begin
        state_d = RUN;
      end
      RUN: begin
        if (terminal) begin
          if (!last_phase) begin
            state_d = CLEAR;
            phase_d = phase_q + PW'(1);
          end else if (LOOP != 0) begin
            state_d   = CLEAR;
            phase_d   = '0;
            loop_done = 1'b1;
          end else begin
            state_d = DONE;
          end
        end else if (sif.pause) begin
          state_d = PAUSE;
        end
      end
      PAUSE: begin
        if (!sif.pause) state_d = RUN;
      end
      DONE: begin
        state_d = IDLE;
        phase_d = '0;
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
    // Abort overrides every transition except in IDLE.
    if (sif.abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      phase_d   = '0;
      loop_done = 1'b0;
    end
    busy_d   = (state_d != IDLE);
    paused_d = (state_d == PAUSE);
    done_d   = (state_d == DONE) || loop_done;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      dur_q    <= '0;
      busy_q   <= 1'b0;
      paused_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      dur_q    <= dur_d;
      busy_q   <= busy_d;
      paused_q <= paused_d;
      done_q   <= done_d;
    end
  end

  assign sif.counten = (state_q == RUN) && !sif.abort && !sif.pause && (sif.count < dur_sel);
  assign sif.cntclr  = (state_q == IDLE) || (state_q == CLEAR) || (state_q == DONE);
  assign sif.phase   = phase_q;
  assign sif.busy    = busy_q;
  assign sif.paused  = paused_q;
  assign sif.done    = done_q;

endmodule
